// File: rtl/ibuff_pkg.sv
// Shared types and the lane prefix-count helper for the instruction buffer queue.
// FETCH_WIDTH / DISPATCH_WIDTH fall back to 2 when the build does not define them.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 2
`endif

package ibuff_pkg;
  localparam int MAX_LANES = 32;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_INDEX = $clog2(DEF_DEPTH);

  typedef logic [DEF_WIDTH-1:0] entry_t;
  typedef logic [DEF_INDEX-1:0] ptr_t;
  typedef logic [DEF_INDEX:0]   cnt_t;

  // Number of set bits in v below bit position k (k == lane count gives the total).
  function automatic int unsigned prefix_count(input logic [MAX_LANES-1:0] v,
                                               input int unsigned k);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < k) n = n + {31'd0, v[i]};
    end
    return n;
  endfunction
endpackage

// File: rtl/ibuff_lane_compact.sv
// Per-lane compaction offsets and total push count derived from the write-valid mask.
module ibuff_lane_compact
  import ibuff_pkg::*;
#(
  parameter int WR_LANES = 4,
  parameter int OFF_W    = 4,
  parameter int CNT_W    = 5
) (
  input  logic [WR_LANES-1:0]       wr_valid_i,
  output logic [WR_LANES*OFF_W-1:0] offset_o,
  output logic [CNT_W-1:0]          push_cnt_o
);
  logic [MAX_LANES-1:0] valid_ext;

  assign valid_ext = MAX_LANES'(wr_valid_i);

  generate
    for (genvar gi = 0; gi < WR_LANES; gi++) begin : g_off
      assign offset_o[gi*OFF_W +: OFF_W] = OFF_W'(prefix_count(valid_ext, gi));
    end
  endgenerate

  assign push_cnt_o = CNT_W'(prefix_count(valid_ext, WR_LANES));
endmodule

// File: rtl/ibuff_queue.sv
// Circular instruction buffer: compacting multi-lane push, fixed-group pop, flush.
// Optional IBUFF_PARITY_EN adds a per-entry even-parity bit checked on every pop.
module ibuff_queue
  import ibuff_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int WR_LANES = 2*`FETCH_WIDTH,
  parameter int RD_LANES = `DISPATCH_WIDTH,
  parameter int INDEX    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic [WR_LANES*WIDTH-1:0] wr_data_i,
  input  logic [WR_LANES-1:0]       wr_valid_i,
  output logic                      stall_o,
  output logic [RD_LANES*WIDTH-1:0] rd_data_o,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [INDEX:0]            count_o,
  output logic                      empty_o,
  output logic                      parity_err_o
);
  localparam int CW = INDEX + 1;
`ifdef IBUFF_PARITY_EN
  localparam int RAM_W = WIDTH + 1;
`else
  localparam int RAM_W = WIDTH;
`endif
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - WR_LANES);
  localparam logic [CW-1:0] RD_C     = CW'(RD_LANES);

  logic [RAM_W-1:0] ram_q [DEPTH];

  logic [INDEX-1:0] head_q, head_d;
  logic [INDEX-1:0] tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WR_LANES*INDEX-1:0] offset;
  logic [CW-1:0]             push_cnt;
  logic                      push_en;
  logic                      pop_en;

  logic [INDEX-1:0] wr_addr  [WR_LANES];
  logic [RAM_W-1:0] wr_entry [WR_LANES];
  logic [RAM_W-1:0] rd_word  [RD_LANES];

  ibuff_lane_compact #(
    .WR_LANES (WR_LANES),
    .OFF_W    (INDEX),
    .CNT_W    (CW)
  ) u_compact (
    .wr_valid_i (wr_valid_i),
    .offset_o   (offset),
    .push_cnt_o (push_cnt)
  );

  // Status is decoded purely from the registered count.
  assign stall_o    = (count_q > STALL_TH);
  assign rd_valid_o = (count_q >= RD_C);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

  assign push_en = !flush_i && !stall_o && (|wr_valid_i);
  assign pop_en  = !flush_i && rd_valid_o && rd_ready_i;

  generate
    for (genvar gi = 0; gi < WR_LANES; gi++) begin : g_wr
      logic [WIDTH-1:0] lane_data;
      assign lane_data   = wr_data_i[gi*WIDTH +: WIDTH];
      assign wr_addr[gi] = tail_q + offset[gi*INDEX +: INDEX];
`ifdef IBUFF_PARITY_EN
      assign wr_entry[gi] = {^lane_data, lane_data};
`else
      assign wr_entry[gi] = lane_data;
`endif
    end

    for (genvar gi = 0; gi < RD_LANES; gi++) begin : g_rd
      logic [INDEX-1:0] rd_addr;
      assign rd_addr     = head_q + INDEX'(gi);
      assign rd_word[gi] = ram_q[rd_addr];
      assign rd_data_o[gi*WIDTH +: WIDTH] = rd_word[gi][WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) tail_d = tail_q + push_cnt[INDEX-1:0];
      if (pop_en)  head_d = head_q + RD_C[INDEX-1:0];
      count_d = count_q + (push_en ? push_cnt : '0) - (pop_en ? RD_C : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is abandoned.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      for (int k = 0; k < WR_LANES; k++) begin
        if (wr_valid_i[k]) ram_q[wr_addr[k]] <= wr_entry[k];
      end
    end
  end

`ifdef IBUFF_PARITY_EN
  logic [RD_LANES-1:0] lane_err;
  logic                parity_err_q, parity_err_d;

  generate
    for (genvar gi = 0; gi < RD_LANES; gi++) begin : g_par
      assign lane_err[gi] = ^rd_word[gi];
    end
  endgenerate

  // pop_en already excludes flush, so a flush cycle never raises the flag.
  assign parity_err_d = pop_en && (|lane_err);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end

  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ibuff_queue.sv
// Scoreboard bench for ibuff_queue (WIDTH=8, DEPTH=16, WR_LANES=4, RD_LANES=2).
`timescale 1ns/1ps
module tb_ibuff_queue;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int WL = 4;
  localparam int RL = 2;
  localparam int IX = 4;
`ifdef IBUFF_PARITY_EN
  localparam logic PERR = 1'b1;
`else
  localparam logic PERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            flush_i;
  logic [WL*W-1:0] wr_data_i;
  logic [WL-1:0]   wr_valid_i;
  logic            stall_o;
  logic [RL*W-1:0] rd_data_o;
  logic            rd_valid_o;
  logic            rd_ready_i;
  logic [IX:0]     count_o;
  logic            empty_o;
  logic            parity_err_o;

  always #5 clk = ~clk;

  ibuff_queue #(.WIDTH(W), .DEPTH(D), .WR_LANES(WL), .RD_LANES(RL), .INDEX(IX)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .wr_data_i    (wr_data_i),
    .wr_valid_i   (wr_valid_i),
    .stall_o      (stall_o),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .rd_ready_i   (rd_ready_i),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .parity_err_o (parity_err_o)
  );

  int         errors = 0;
  int         checks = 0;
  int         m_cnt  = 0;
  logic [7:0] dval   = 8'h40;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk4(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd1;
    b2 = b + 8'd2;
    b3 = b + 8'd3;
    return {b3, b2, b1, b};
  endfunction

  // One cycle: drive inputs, update the model and expected-data queue, then check status.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic rdy, input logic fl);
    bit push, pop;
    wr_valid_i = v;
    wr_data_i  = d;
    rd_ready_i = rdy;
    flush_i    = fl;
    push = !fl && (m_cnt <= D - WL) && (v != 4'd0);
    pop  = !fl && (m_cnt >= RL) && rdy;
    if (fl) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (push)
        for (int k = 0; k < WL; k++)
          if (v[k]) exp_q.push_back(d[k*8 +: 8]);
      m_cnt = m_cnt + (push ? $countones(v) : 0) - (pop ? RL : 0);
    end
    $display("cycle v=%b d=%h rdy=%b fl=%b -> model count %0d", v, d, rdy, fl, m_cnt);
    @(posedge clk);
    #1;
    wr_valid_i = '0;
    rd_ready_i = 1'b0;
    flush_i    = 1'b0;
    chk("count", count_o, m_cnt);
    chk("empty", empty_o, m_cnt == 0);
    chk("stall", stall_o, m_cnt > D - WL);
    chk("rd_valid", rd_valid_o, m_cnt >= RL);
  endtask

  task automatic push4();
    cycle(4'hF, mk4(dval), 1'b0, 1'b0);
    dval = dval + 8'd4;
  endtask

  // Monitor: every accepted pop is compared against the front of the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && rd_valid_o === 1'b1 && rd_ready_i === 1'b1 && flush_i === 1'b0) begin
        for (int j = 0; j < RL; j++) begin
          logic [7:0] e;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got lane%0d=0x%0h expected no pop", j, rd_data_o[j*8 +: 8]);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("pop_lane%0d", j), rd_data_o[j*8 +: 8], e);
          end
        end
        $display("pop lanes %h %h", rd_data_o[7:0], rd_data_o[15:8]);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    flush_i    = 1'b0;
    wr_data_i  = '0;
    wr_valid_i = '0;
    rd_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_stall", stall_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_parity", parity_err_o, 0);
    reset = 1'b0;

    // Full four-lane push then a group pop.
    cycle(4'hF, 32'h13121110, 1'b0, 1'b0);
    chk("t1_count", count_o, 4);
    chk("t1_lane0", rd_data_o[7:0], 8'h10);
    chk("t1_lane1", rd_data_o[15:8], 8'h11);
    cycle(4'h0, 32'h0, 1'b1, 1'b0);
    chk("t1_pop_count", count_o, 2);
    chk("t1_pop_lane0", rd_data_o[7:0], 8'h12);
    chk("t1_pop_lane1", rd_data_o[15:8], 8'h13);
    cycle(4'h0, 32'h0, 1'b1, 1'b0);

    // Sparse mask compacts into consecutive entries.
    cycle(4'b1010, 32'h33221100, 1'b0, 1'b0);
    chk("t2_count", count_o, 2);
    chk("t2_lane0", rd_data_o[7:0], 8'h11);
    chk("t2_lane1", rd_data_o[15:8], 8'h33);
    cycle(4'h0, 32'h0, 1'b1, 1'b0);

    // Fill to 13, dropped push under stall, recovery.
    repeat (3) push4();
    cycle(4'b0001, {24'h0, dval}, 1'b0, 1'b0);
    dval = dval + 8'd1;
    chk("t3_count13", count_o, 13);
    chk("t3_stall", stall_o, 1);
    cycle(4'hF, 32'hEEEEEEEE, 1'b0, 1'b0);
    chk("t3_dropped", count_o, 13);
    cycle(4'h0, 32'h0, 1'b1, 1'b0);
    chk("t3_pop_count", count_o, 11);
    chk("t3_unstall", stall_o, 0);
    push4();
    chk("t3_count15", count_o, 15);
    repeat (7) cycle(4'h0, 32'h0, 1'b1, 1'b0);
    chk("t3_drained", count_o, 1);
    cycle(4'h0, 32'h0, 1'b0, 1'b1);

    // Sustained push 2 / pop 2 across pointer wrap.
    cycle(4'b0011, {16'h0, dval + 8'd1, dval}, 1'b0, 1'b0);
    dval = dval + 8'd2;
    for (int i = 0; i < 40; i++) begin
      cycle(4'b0011, {16'h0, dval + 8'd1, dval}, 1'b1, 1'b0);
      dval = dval + 8'd2;
      chk("t4_count", count_o, 2);
    end
    cycle(4'h0, 32'h0, 1'b0, 1'b1);

    // Flush beats simultaneous push and pop; ready without a full group is ignored.
    push4();
    cycle(4'b0011, {16'h0, dval + 8'd1, dval}, 1'b0, 1'b0);
    dval = dval + 8'd2;
    chk("t5_count6", count_o, 6);
    cycle(4'hF, 32'h55555555, 1'b1, 1'b1);
    chk("t5_flush_count", count_o, 0);
    chk("t5_flush_empty", empty_o, 1);
    chk("t5_flush_rdv", rd_valid_o, 0);
    cycle(4'b0001, {24'h0, dval}, 1'b0, 1'b0);
    dval = dval + 8'd1;
    cycle(4'h0, 32'h0, 1'b1, 1'b0);
    chk("t5_no_pop", count_o, 1);

    // Parity: corrupt the stored parity bit of head entry, then pop it.
    cycle(4'b0001, {24'h0, dval}, 1'b0, 1'b0);
    dval = dval + 8'd1;
`ifdef IBUFF_PARITY_EN
    dut.ram_q[0][W] = ~dut.ram_q[0][W];
`endif
    cycle(4'h0, 32'h0, 1'b1, 1'b0);
    chk("t6_parity_pulse", parity_err_o, PERR);
    cycle(4'h0, 32'h0, 1'b0, 1'b0);
    chk("t6_parity_clear", parity_err_o, 0);

    // Asynchronous reset mid-operation clears occupancy immediately.
    push4();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", count_o, 0);
    chk("async_rst_empty", empty_o, 1);
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(4'h0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
